// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// one sign fix-up cycle, then a one-cycle FIN that pulses DONE/REG_WR.
module mdu_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        START,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    input  logic [4:0]  RD_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic [4:0]  DIR_WR,
    output logic        REG_WR
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mc_q, mc_d;
    logic [31:0] mp_q, mp_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  dir_q, dir_d;

    logic        is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf, fast;
    logic [31:0] fast_res;
    logic [32:0] rem_sh, diff;
    logic [63:0] prod;
    logic [31:0] quo, rem, fix_res;

    // Operand signedness: div ops key off FUNCT3[0]; only MULHU has unsigned A.
    assign is_div   = FUNCT3[2];
    assign a_sgn    = is_div ? ~FUNCT3[0] : (FUNCT3 != 3'b011);
    assign b_sgn    = is_div ? ~FUNCT3[0] : ~FUNCT3[1];
    assign a_neg    = a_sgn & OP_A[31];
    assign b_neg    = b_sgn & OP_B[31];
    assign mag_a    = a_neg ? (32'd0 - OP_A) : OP_A;
    assign mag_b    = b_neg ? (32'd0 - OP_B) : OP_B;

    assign div_zero = (OP_B == 32'd0);
    assign div_ovf  = ~FUNCT3[0] & (OP_A == 32'h8000_0000) & (OP_B == 32'hFFFF_FFFF);
    assign fast     = is_div & (div_zero | div_ovf);
    assign fast_res = div_zero ? (FUNCT3[1] ? OP_A : 32'hFFFF_FFFF)
                               : (FUNCT3[1] ? 32'd0 : 32'h8000_0000);

    // Restoring step: remainder lives in acc_q[31:0], dividend/quotient in mp_q.
    assign rem_sh   = {acc_q[31:0], mp_q[31]};
    assign diff     = rem_sh - {1'b0, mc_q[31:0]};

    assign prod     = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quo      = neg_q ? (32'd0 - mp_q) : mp_q;
    assign rem      = rneg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign fix_res  = op_q[2] ? (op_q[1] ? rem : quo)
                              : ((op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    op_d   = FUNCT3;
                    rd_d   = RD_IN;
                    cnt_d  = 6'd0;
                    acc_d  = 64'd0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (fast) begin
                        result_d = fast_res;
                        dir_d    = RD_IN;
                        state_d  = FIN;
                    end else begin
                        state_d = CALC;
                        if (is_div) begin
                            mc_d = {32'd0, mag_b};
                            mp_d = mag_a;
                        end else begin
                            mc_d = {32'd0, mag_a};
                            mp_d = mag_b;
                        end
                    end
                end
            end
            CALC: begin
                // Count 32 is the extra fix-up cycle that applies the signs.
                if (cnt_q == 6'd32) begin
                    result_d = fix_res;
                    dir_d    = rd_q;
                    state_d  = FIN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (op_q[2]) begin
                        acc_d = {32'd0, (diff[32] ? rem_sh[31:0] : diff[31:0])};
                        mp_d  = {mp_q[30:0], ~diff[32]};
                    end else begin
                        if (mp_q[0]) begin
                            acc_d = acc_q + mc_q;
                        end
                        mc_d = {mc_q[62:0], 1'b0};
                        mp_d = {1'b0, mp_q[31:1]};
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            acc_q    <= 64'd0;
            mc_q     <= 64'd0;
            mp_q     <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
            dir_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            dir_q    <= dir_d;
        end
    end

    assign BUSY   = (state_q != IDLE);
    assign DONE   = (state_q == FIN);
    assign RESULT = result_q;
    assign DIR_WR = dir_q;
    assign REG_WR = DONE & (dir_q != 5'd0);
endmodule
